// File: rtl/stream_compact_pkg.sv
// Shared definitions for the pfxsum / stream_compact pipeline: FSM encoding and
// lane packing width helpers.
package stream_compact_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SCATTER = 2'd1,
      DRAIN   = 2'd2
   } state_t;

   // Width of a vector of `lanes` elements, each `w` bits wide.
   function automatic int vec_w(input int lanes, input int w);
      return lanes * w;
   endfunction

   // Counter width able to hold 0..lanes inclusive.
   function automatic int cnt_w(input int lanes);
      return $clog2(lanes + 1);
   endfunction

   // Address width for slots 0..lanes-1.
   function automatic int slot_w(input int lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

endpackage

// File: rtl/stream_compact_buf.sv
// compact_buf: V_LEN x IWIDTH slot store, all lanes scatter-written in one edge, one async read.
// Out-of-range slots are ignored; on colliding slots the higher lane index wins.
module compact_buf
   import stream_compact_pkg::*;
#(
   parameter int IWIDTH = 8,
   parameter int V_LEN  = 16
) (
   input  logic                             clk,
   input  logic                             i_wr_en,
   input  logic [V_LEN-1:0]                 i_wr_mask,
   input  logic [vec_w(V_LEN, IWIDTH)-1:0]  i_wr_data,
   input  logic [vec_w(V_LEN, IWIDTH)-1:0]  i_wr_slot,
   input  logic [slot_w(V_LEN)-1:0]         i_rd_slot,
   output logic [IWIDTH-1:0]                o_rd_data
);

   localparam int AW = slot_w(V_LEN);

   logic [IWIDTH-1:0] r_mem [V_LEN];

   // Ascending loop order makes the last (highest) lane's write stick.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         for (int n = 0; n < V_LEN; n++) begin
            if (i_wr_mask[n] && (int'(i_wr_slot[n*IWIDTH +: IWIDTH]) < V_LEN)) begin
               r_mem[i_wr_slot[n*IWIDTH +: AW]] <= i_wr_data[n*IWIDTH +: IWIDTH];
            end
         end
      end
   end

   assign o_rd_data = r_mem[i_rd_slot];

endmodule

// File: rtl/stream_compact.sv
// stream_compact: scatters kept lanes to their prefix-sum slots, then drains slots 0..total-1.
// Accept->first beat 2 cycles; one vector in flight; out_ready stalls hold the current beat.
module stream_compact
   import stream_compact_pkg::*;
#(
   parameter int IWIDTH = 8,
   parameter int V_LEN  = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             valid_in,
   output logic                             ready_in,
   input  logic [vec_w(V_LEN, IWIDTH)-1:0]  dvec,
   input  logic [V_LEN-1:0]                 keep,
   input  logic [vec_w(V_LEN, IWIDTH)-1:0]  ovec,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [IWIDTH-1:0]                out_data,
   output logic                             out_last,
   output logic                             done,
   output logic [cnt_w(V_LEN)-1:0]          total,
   output logic                             err
);

   localparam int CW = cnt_w(V_LEN);
   localparam int AW = slot_w(V_LEN);
   localparam int DW = vec_w(V_LEN, IWIDTH);

   state_t              r_state;
   logic [DW-1:0]       r_dvec;
   logic [DW-1:0]       r_ovec;
   logic [V_LEN-1:0]    r_keep;
   logic [CW-1:0]       r_idx;
   logic [CW-1:0]       r_total;
   logic                r_out_valid;
   logic [IWIDTH-1:0]   r_out_data;
   logic                r_out_last;
   logic                r_done;
   logic                r_err;

   logic [IWIDTH:0]     w_sum;
   logic [CW-1:0]       w_total;
   logic                w_drop;
   logic [CW-1:0]       w_idx_nxt;
   logic                w_is_last;
   logic [IWIDTH-1:0]   w_rd_data;

   always_comb begin
      w_sum   = {1'b0, r_ovec[(V_LEN-1)*IWIDTH +: IWIDTH]} + {{IWIDTH{1'b0}}, r_keep[V_LEN-1]};
      w_total = (int'(w_sum) > V_LEN) ? CW'(V_LEN) : w_sum[CW-1:0];
      w_drop  = 1'b0;
      for (int n = 0; n < V_LEN; n++) begin
         if (r_keep[n] && (int'(r_ovec[n*IWIDTH +: IWIDTH]) >= V_LEN)) begin
            w_drop = 1'b1;
         end
      end
   end

   assign w_idx_nxt = r_idx + CW'(1);
   assign w_is_last = (w_idx_nxt == r_total);

   // Vector capture needs no reset: it is only consumed after an accept.
   always_ff @(posedge clk) begin
      if (valid_in && ready_in) begin
         r_dvec <= dvec;
         r_keep <= keep;
         r_ovec <= ovec;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_idx       <= '0;
         r_total     <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (valid_in) r_state <= SCATTER;
            end
            SCATTER: begin
               r_total <= w_total;
               r_idx   <= '0;
               if (w_drop) r_err <= 1'b1;
               if (w_total == '0) begin
                  r_done  <= 1'b1;
                  r_state <= IDLE;
               end else begin
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               // First DRAIN cycle has no beat yet: it loads slot 0 from the freshly written buffer.
               if (!r_out_valid || out_ready) begin
                  if (r_out_last) begin
                     r_out_valid <= 1'b0;
                     r_out_last  <= 1'b0;
                     r_done      <= 1'b1;
                     r_state     <= IDLE;
                  end else begin
                     r_out_valid <= 1'b1;
                     r_out_data  <= w_rd_data;
                     r_out_last  <= w_is_last;
                     r_idx       <= w_idx_nxt;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   compact_buf #(
      .IWIDTH (IWIDTH),
      .V_LEN  (V_LEN)
   ) u_buf (
      .clk       (clk),
      .i_wr_en   (r_state == SCATTER),
      .i_wr_mask (r_keep),
      .i_wr_data (r_dvec),
      .i_wr_slot (r_ovec),
      .i_rd_slot (r_idx[AW-1:0]),
      .o_rd_data (w_rd_data)
   );

   assign ready_in  = (r_state == IDLE);
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign done      = r_done;
   assign total     = r_total;
   assign err       = r_err;

endmodule
